// File: rtl/fitbit_display_scheduler.sv
// Rotates STEPS/DIST/ACTIVE/RATE on a 1 s timebase. count->value is 1 cycle, update 1 cycle later. No backpressure.
// Define GOAL_BLINK_EN to make goal_led toggle on every tick once the goal is met. Otherwise it stays steady high.
module fitbit_display_scheduler #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DWELL_SEC     = 2,
    parameter int ACTIVE_THRESH = 32
) (
    input  logic        clk100MHz,
    input  logic        reset,
    input  logic [19:0] count,
    input  logic        goal_met,
    input  logic        hold,
    output logic [1:0]  mode,
    output logic [13:0] value,
    output logic        update,
    output logic        goal_led
);

    localparam int              PW         = $clog2(CLK_HZ);
    localparam int              DW         = $clog2(DWELL_SEC + 1);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL_SEC - 1);
    localparam logic [19:0]     SAT20      = 20'd9999;
    localparam logic [13:0]     SAT14      = 14'd9999;
    localparam logic [19:0]     THRESH     = 20'(ACTIVE_THRESH);

    typedef enum logic [1:0] {SHOW0, SHOW1, SHOW2, SHOW3} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [19:0]   prev_q, prev_d;
    logic [13:0]   rate_q, rate_d;
    logic [13:0]   active_q, active_d;
    logic [13:0]   value_q, value_d;
    logic [15:0]   last_q, last_d;
    logic          update_q, update_d;
    logic          goal_q, goal_d;

    logic          tick;
    logic [19:0]   diff;
    logic [19:0]   delta;
    logic          restart;

    assign tick = (presc_q == PRESC_LAST);

    // A backward jump of less than half the range is a counter restart;
    // a larger one is the 20-bit total wrapping, where modulo diff is right.
    assign diff    = count - prev_q;
    assign restart = (count < prev_q) && diff[19];
    assign delta   = restart ? count : diff;

    always_comb begin
        presc_d  = tick ? '0 : presc_q + PW'(1);
        prev_d   = prev_q;
        rate_d   = rate_q;
        active_d = active_q;
        if (tick) begin
            prev_d = count;
            rate_d = (delta > SAT20) ? SAT14 : delta[13:0];
            if ((delta > THRESH) && (active_q != SAT14)) begin
                active_d = active_q + 14'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (hold) begin
            dwell_d = '0;
        end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                state_d = state_t'(state_q + 2'd1);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    // Value follows the next state so mode and value switch on the same edge.
    always_comb begin
        value_d = '0;
        case (state_d)
            SHOW0:   value_d = (count > SAT20) ? SAT14 : count[13:0];
            SHOW1:   value_d = {4'd0, count[19:10]};
            SHOW2:   value_d = active_q;
            SHOW3:   value_d = rate_q;
            default: value_d = '0;
        endcase
    end

    always_comb begin
        last_d   = {state_q, value_q};
        update_d = ({state_q, value_q} != last_q);
        goal_d   = goal_q | goal_met;
    end

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= SHOW0;
            presc_q  <= '0;
            dwell_q  <= '0;
            prev_q   <= '0;
            rate_q   <= '0;
            active_q <= '0;
            value_q  <= '0;
            last_q   <= '0;
            update_q <= 1'b0;
            goal_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            dwell_q  <= dwell_d;
            prev_q   <= prev_d;
            rate_q   <= rate_d;
            active_q <= active_d;
            value_q  <= value_d;
            last_q   <= last_d;
            update_q <= update_d;
            goal_q   <= goal_d;
        end
    end

`ifdef GOAL_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (!goal_q && goal_met) begin
            blink_d = 1'b1;
        end else if (goal_q && tick) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign goal_led = blink_q;
`else
    assign goal_led = goal_q;
`endif

    assign mode   = state_q;
    assign value  = value_q;
    assign update = update_q;

endmodule

// File: tb/tb_fitbit_display_scheduler.sv
// Randomised and directed stimulus against a cycle-level behavioural model of the display scheduler.
module tb_fitbit_display_scheduler;

    localparam int CLK_HZ = 10;
    localparam int DWELL  = 2;
    localparam int THR    = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] count = '0;
    logic        goal_met = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  mode;
    logic [13:0] value;
    logic        update;
    logic        goal_led;

    always #5 clk = ~clk;

    fitbit_display_scheduler #(
        .CLK_HZ(CLK_HZ), .DWELL_SEC(DWELL), .ACTIVE_THRESH(THR)
    ) dut (
        .clk100MHz(clk), .reset(rst_n), .count(count), .goal_met(goal_met),
        .hold(hold), .mode(mode), .value(value), .update(update), .goal_led(goal_led)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // reference model state
    int m_phase, m_prev, m_rate, m_active, m_mode, m_ticks, m_value;
    int m_upd, m_goal, m_led, p1, p2;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, ncyc, got, exp);
        end
    endtask

    function automatic int metric(input int md);
        int c;
        c = int'(count);
        case (md)
            0:       return (c > 9999) ? 9999 : c;
            1:       return c / 1024;
            2:       return m_active;
            default: return m_rate;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_rate = 0; m_active = 0; m_mode = 0;
        m_ticks = 0; m_value = 0; m_upd = 0; m_goal = 0; m_led = 0;
        p1 = 0; p2 = 0;
    endtask

    task automatic model_edge();
        bit tk;
        int c, fwd, d;
        tk = (m_phase == CLK_HZ - 1);
        m_phase = (m_phase + 1) % CLK_HZ;
        m_upd = (p1 != p2) ? 1 : 0;
        if (hold) begin
            m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == DWELL) begin
                m_ticks = 0;
                m_mode = (m_mode + 1) % 4;
            end
        end
        m_value = metric(m_mode);
        if (tk) begin
            c = int'(count);
            fwd = (c - m_prev + (1 << 20)) % (1 << 20);
            d = (c < m_prev && fwd >= (1 << 19)) ? c : fwd;
            m_rate = (d > 9999) ? 9999 : d;
            if (d > THR && m_active < 9999) m_active++;
            m_prev = c;
        end
`ifdef GOAL_BLINK_EN
        if (m_goal == 0 && goal_met) m_led = 1;
        else if (m_goal == 1 && tk) m_led = 1 - m_led;
        if (goal_met) m_goal = 1;
`else
        if (goal_met) m_goal = 1;
        m_led = m_goal;
`endif
        p2 = p1;
        p1 = m_mode * 16384 + m_value;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        ncyc++;
        @(negedge clk);
        check_eq("mode", int'(mode), m_mode);
        check_eq("value", int'(value), m_value);
        check_eq("update", int'(update), m_upd);
        check_eq("goal_led", int'(goal_led), m_led);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mode", int'(mode), 0);
        check_eq("rst_value", int'(value), 0);
        check_eq("rst_update", int'(update), 0);
        check_eq("rst_goal_led", int'(goal_led), 0);
        model_reset();
        ncyc = 0;
        count = '0;
        hold = 1'b0;
        goal_met = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        model_reset();

        // idle rotation
        do_reset();
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (ncyc == 19) check_eq("idle_mode19", int'(mode), 0);
            if (ncyc == 20) check_eq("idle_mode20", int'(mode), 1);
            if (ncyc == 79) check_eq("idle_mode79", int'(mode), 3);
            if (ncyc == 80) check_eq("idle_mode80", int'(mode), 0);
        end

        // STEPS value and saturation
        do_reset();
        cycle(); cycle();
        count = 20'd5000;
        cycle();
        check_eq("steps_5000", int'(value), 5000);
        cycle();
        check_eq("steps_upd1", int'(update), 1);
        cycle();
        check_eq("steps_upd0", int'(update), 0);
        count = 20'd12000;
        cycle();
        check_eq("steps_sat", int'(value), 9999);
        cycle();
        check_eq("sat_upd", int'(update), 1);
        repeat (3) cycle();

        // +40 first second, then +10 per second
        do_reset();
        for (int i = 0; i < 70; i++) begin
            count = (i < 10) ? 20'd40 : 20'(40 + 10 * (i / 10));
            cycle();
            if (ncyc == 45) check_eq("rate_active", int'(value), 1);
            if (ncyc == 65) check_eq("rate_10", int'(value), 10);
        end

        // step-counter restart
        do_reset();
        for (int i = 0; i < 50; i++) begin
            count = (i < 10) ? 20'd1000 : 20'd7;
            cycle();
            if (ncyc == 45) check_eq("restart_active", int'(value), 1);
        end

        // 20-bit wrap with exactly-threshold delta
        do_reset();
        for (int i = 0; i < 70; i++) begin
            count = 20'((32'hFFFF0 + 32 * (i / 10)) & 32'hFFFFF);
            cycle();
            if (ncyc == 45) check_eq("wrap_active", int'(value), 1);
            if (ncyc == 65) check_eq("wrap_rate", int'(value), 32);
        end

        // hold in DIST
        do_reset();
        count = 20'd4096;
        while (ncyc < 21) cycle();
        hold = 1'b1;
        repeat (30) cycle();
        check_eq("hold_mode", int'(mode), 1);
        check_eq("hold_value", int'(value), 4);
        hold = 1'b0;
        while (ncyc < 75) begin
            cycle();
            if (ncyc == 69) check_eq("hold_rel69", int'(mode), 1);
            if (ncyc == 70) check_eq("hold_rel70", int'(mode), 2);
        end

        // goal latch, then reset mid-dwell
        do_reset();
        repeat (3) cycle();
        goal_met = 1'b1;
        cycle();
        goal_met = 1'b0;
        check_eq("goal_set", int'(goal_led), 1);
        repeat (25) cycle();
        do_reset();

        // randomised traffic with a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            r = $urandom_range(0, 99);
            if (r < 30) count = count + 20'($urandom_range(0, 15));
            else if (r == 99) count = 20'($urandom_range(0, 50));
            else if (r == 98) count = 20'hFFFF0 + 20'($urandom_range(0, 8));
            else if (r == 97) count = count + 20'($urandom_range(0, 3000));
            if ($urandom_range(0, 99) < 3) hold = ~hold;
            goal_met = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
